dft_point: RTL and testbench

DFT_POINT -- requirements
Module: dft_point

---
 rtl/dft_pkg.sv | 68 ++++++
 rtl/dft_twiddle_rom.sv | 28 ++
 rtl/dft_point.sv | 162 ++++++++++++++++
 tb/tb_dft_point.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dft_pkg.sv
// Shared constants and the elaboration-time twiddle generator for the single-bin DFT engine.
// Twiddles are built with fixed-point Taylor series so no real arithmetic reaches the netlist.
package dft_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_ROUND = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Twiddles need two bits above FRAC: one for the value 1.0 and one for sign.
  localparam int TW_GUARD = 2;

  localparam longint TWO_PI_Q30 = 64'sd6746518852;

  function automatic longint roundQ30(input longint v, input int frac);
    longint mag;
    mag = (v < 0) ? -v : v;
    mag = ((mag <<< frac) + (64'sd1 <<< 29)) >>> 30;
    return (v < 0) ? -mag : mag;
  endfunction

  // Only the first quadrant is evaluated; the other three are exact sign/swap
  // copies of it, which guarantees W[m+N/2] = -W[m] bit for bit.
  function automatic int twiddleVal(input int m, input int n, input int frac, input bit wantSin);
    int     quarter;
    int     mm;
    int     q;
    int     r;
    longint a;
    longint a2;
    longint term;
    longint sinV;
    longint cosV;
    longint cr;
    longint sr;
    longint res;
    quarter = n / 4;
    mm      = m % n;
    q       = mm / quarter;
    r       = mm % quarter;
    a       = (TWO_PI_Q30 * longint'(r)) / longint'(n);
    a2      = (a * a) >>> 30;
    sinV    = 0;
    cosV    = 0;
    term    = a;
    for (int i = 1; i <= 12; i++) begin
      sinV += term;
      term  = -(((term * a2) >>> 30) / longint'((2 * i) * (2 * i + 1)));
    end
    term = 64'sd1 <<< 30;
    for (int i = 1; i <= 12; i++) begin
      cosV += term;
      term  = -(((term * a2) >>> 30) / longint'((2 * i - 1) * (2 * i)));
    end
    cr = roundQ30(cosV, frac);
    sr = roundQ30(sinV, frac);
    case (q)
      0:       res = wantSin ? sr  : cr;
      1:       res = wantSin ? cr  : -sr;
      2:       res = wantSin ? -sr : -cr;
      default: res = wantSin ? -cr : sr;
    endcase
    return int'(res);
  endfunction

endpackage

// File: rtl/dft_twiddle_rom.sv
// Combinational twiddle lookup: c + j*s = exp(j*2*pi*index/SAMPLES) scaled by 2^FRAC.
module dft_twiddle_rom
  import dft_pkg::*;
#(
  parameter int SAMPLES = 32,
  parameter int FRAC    = 8
) (
  input  logic        [$clog2(SAMPLES)-1:0] index,
  output logic signed [FRAC+TW_GUARD-1:0]   c,
  output logic signed [FRAC+TW_GUARD-1:0]   s
);

  localparam int TW = FRAC + TW_GUARD;

  logic signed [TW-1:0] cosTab [SAMPLES];
  logic signed [TW-1:0] sinTab [SAMPLES];

  for (genvar m = 0; m < SAMPLES; m++) begin : gTab
    localparam int CV = twiddleVal(m, SAMPLES, FRAC, 1'b0);
    localparam int SV = twiddleVal(m, SAMPLES, FRAC, 1'b1);
    assign cosTab[m] = TW'(CV);
    assign sinTab[m] = TW'(SV);
  end

  assign c = cosTab[index];
  assign s = sinTab[index];

endmodule

// File: rtl/dft_point.sv
// Computes one DFT/IDFT bin X[k] over a parallel input vector, one complex MAC per cycle,
// then rounds and saturates the wide accumulator into WIDTH-bit results.
module dft_point
  import dft_pkg::*;
#(
  parameter int WIDTH     = 24,
  parameter int FRAC      = 8,
  parameter int SAMPLES   = 32,
  parameter int SCALE_INV = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 inverse,
  input  logic [$clog2(SAMPLES)-1:0]           dft_idx,
  input  logic [SAMPLES-1:0][WIDTH-1:0]        src_real,
  input  logic [SAMPLES-1:0][WIDTH-1:0]        src_imag,
  output logic                                 busy,
  output logic                                 ready,
  output logic [WIDTH-1:0]                     dft_real,
  output logic [WIDTH-1:0]                     dft_imag
);

  localparam int IDXW      = $clog2(SAMPLES);
  localparam int TW        = FRAC + TW_GUARD;
  localparam int PRODW     = WIDTH + TW;
  localparam int ACCW      = WIDTH + FRAC + 2 + IDXW;
  localparam int SHIFT_FWD = FRAC;
  localparam int SHIFT_INV = FRAC + ((SCALE_INV == 1) ? IDXW : 0);

  localparam logic signed [ACCW:0] RND_BIAS = (ACCW + 1)'(1) << (FRAC - 1);
  localparam logic signed [ACCW:0] SAT_MAX  = {{(ACCW - WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [ACCW:0] SAT_MIN  = ~SAT_MAX;

  state_t                   stateQ, stateD;
  logic        [IDXW-1:0]   kQ, kD;
  logic                     invQ, invD;
  logic        [IDXW-1:0]   nQ, nD;
  logic        [IDXW-1:0]   twQ, twD;
  logic signed [ACCW-1:0]   accReQ, accReD;
  logic signed [ACCW-1:0]   accImQ, accImD;
  logic        [WIDTH-1:0]  outReQ, outReD;
  logic        [WIDTH-1:0]  outImQ, outImD;

  logic signed [WIDTH-1:0]  xRe, xIm;
  logic signed [TW-1:0]     twC, twS, sEff;
  logic signed [PRODW-1:0]  pA, pB, pC, pD;
  logic signed [ACCW-1:0]   sumRe, sumIm;
  logic signed [ACCW:0]     biasRe, biasIm, shRe, shIm;
  logic        [WIDTH-1:0]  rndRe, rndIm;

  dft_twiddle_rom #(
    .SAMPLES (SAMPLES),
    .FRAC    (FRAC)
  ) uRom (
    .index (twQ),
    .c     (twC),
    .s     (twS)
  );

  // Forward uses conj(W), i.e. the sine term negated; the MAC itself is shared.
  assign xRe  = src_real[nQ];
  assign xIm  = src_imag[nQ];
  assign sEff = invQ ? twS : -twS;

  assign pA = PRODW'(xRe) * PRODW'(twC);
  assign pB = PRODW'(xIm) * PRODW'(sEff);
  assign pC = PRODW'(xIm) * PRODW'(twC);
  assign pD = PRODW'(xRe) * PRODW'(sEff);

  assign sumRe = accReQ + ACCW'(pA) - ACCW'(pB);
  assign sumIm = accImQ + ACCW'(pC) + ACCW'(pD);

  function automatic logic [WIDTH-1:0] saturate(input logic signed [ACCW:0] v);
    if (v > SAT_MAX) begin
      return {1'b0, {(WIDTH - 1){1'b1}}};
    end else if (v < SAT_MIN) begin
      return {1'b1, {(WIDTH - 1){1'b0}}};
    end
    return v[WIDTH-1:0];
  endfunction

  // Round half up, then drop FRAC bits (plus log2(N) for a scaled inverse).
  always_comb begin
    biasRe = {accReQ[ACCW-1], accReQ} + RND_BIAS;
    biasIm = {accImQ[ACCW-1], accImQ} + RND_BIAS;
    shRe   = invQ ? (biasRe >>> SHIFT_INV) : (biasRe >>> SHIFT_FWD);
    shIm   = invQ ? (biasIm >>> SHIFT_INV) : (biasIm >>> SHIFT_FWD);
    rndRe  = saturate(shRe);
    rndIm  = saturate(shIm);
  end

  always_comb begin
    stateD = stateQ;
    kD     = kQ;
    invD   = invQ;
    nD     = nQ;
    twD    = twQ;
    accReD = accReQ;
    accImD = accImQ;
    outReD = outReQ;
    outImD = outImQ;
    case (stateQ)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          kD     = dft_idx;
          invD   = inverse;
          nD     = '0;
          twD    = '0;
          accReD = '0;
          accImD = '0;
          stateD = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        accReD = sumRe;
        accImD = sumIm;
        nD     = nQ + IDXW'(1);
        twD    = twQ + kQ;
        if (nQ == IDXW'(SAMPLES - 1)) begin
          stateD = ST_ROUND;
        end
      end
      ST_ROUND: begin
        outReD = rndRe;
        outImD = rndIm;
        stateD = ST_DONE;
      end
      default: stateD = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= ST_IDLE;
      kQ     <= '0;
      invQ   <= 1'b0;
      nQ     <= '0;
      twQ    <= '0;
      accReQ <= '0;
      accImQ <= '0;
      outReQ <= '0;
      outImQ <= '0;
    end else begin
      stateQ <= stateD;
      kQ     <= kD;
      invQ   <= invD;
      nQ     <= nD;
      twQ    <= twD;
      accReQ <= accReD;
      accImQ <= accImD;
      outReQ <= outReD;
      outImQ <= outImD;
    end
  end

  assign busy     = (stateQ == ST_ACCUM) || (stateQ == ST_ROUND);
  assign ready    = (stateQ == ST_DONE);
  assign dft_real = outReQ;
  assign dft_imag = outImQ;

endmodule

// File: tb/tb_dft_point.sv
// Bench for dft_point: directed literal cases plus randomized runs checked against a
// real-arithmetic DFT model; a 4-point and a 32-point instance share clock and reset.
module tb_dft_point;

  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              start4, inv4, busy4, ready4;
  logic [1:0]        idx4;
  logic [3:0][23:0]  sr4, si4;
  logic [23:0]       re4, im4;

  logic              start32, inv32, busy32, ready32;
  logic [4:0]        idx32;
  logic [31:0][23:0] sr32, si32;
  logic [23:0]       re32, im32;

  dft_point #(.WIDTH(24), .FRAC(8), .SAMPLES(4), .SCALE_INV(1)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .inverse(inv4), .dft_idx(idx4),
    .src_real(sr4), .src_imag(si4), .busy(busy4), .ready(ready4),
    .dft_real(re4), .dft_imag(im4)
  );

  dft_point #(.WIDTH(24), .FRAC(8), .SAMPLES(32), .SCALE_INV(1)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .inverse(inv32), .dft_idx(idx32),
    .src_real(sr32), .src_imag(si32), .busy(busy32), .ready(ready32),
    .dft_real(re32), .dft_imag(im32)
  );

  int          checks = 0;
  int          passes = 0;
  longint      srcR [32];
  longint      srcI [32];
  logic        compareOn, expValid, expBusy;
  logic [23:0] expRe, expIm;
  logic [23:0] litRe [4] = '{24'h000500, 24'h000000, 24'h000300, 24'h000000};
  logic [23:0] litIm [4] = '{24'h000000, 24'hffff00, 24'h000000, 24'h000100};

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic longint rnd(input real x);
    return (x >= 0.0) ? longint'($floor(x + 0.5)) : -longint'($floor(-x + 0.5));
  endfunction

  function automatic logic [23:0] sat(input longint v);
    longint t;
    t = v;
    if (t > 64'sd8388607) t = 64'sd8388607;
    else if (t < -64'sd8388608) t = -64'sd8388608;
    return t[23:0];
  endfunction

  // Reference: X[k] = sum x[n] * exp(-/+ j*2*pi*n*k/N) with rounded Q.FRAC twiddles.
  function automatic void model(input int n, input int k, input bit inv,
                                output logic [23:0] oRe, output logic [23:0] oIm);
    longint aR, aI, c, s;
    int     sh;
    real    ang;
    aR = 0;
    aI = 0;
    for (int i = 0; i < n; i++) begin
      ang = 2.0 * PI * real'((i * k) % n) / real'(n);
      c   = rnd($cos(ang) * 256.0);
      s   = rnd($sin(ang) * 256.0);
      if (!inv) s = -s;
      aR += srcR[i] * c - srcI[i] * s;
      aI += srcI[i] * c + srcR[i] * s;
    end
    sh  = 8 + (inv ? $clog2(n) : 0);
    oRe = sat((aR + 128) >>> sh);
    oIm = sat((aI + 128) >>> sh);
  endfunction

  task automatic applyStimulus4();
    for (int i = 0; i < 4; i++) begin
      sr4[i] = srcR[i][23:0];
      si4[i] = srcI[i][23:0];
    end
  endtask

  // Called at posedge+1; returns at posedge+1 while the result is being held.
  task automatic runStart4(input int k, input bit inv);
    logic [23:0] mRe, mIm;
    applyStimulus4();
    model(4, k, inv, mRe, mIm);
    idx4   = 2'(k);
    inv4   = inv;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4   = 1'b0;
    expValid = 1'b0;
    expBusy  = 1'b1;
    expRe    = mRe;
    expIm    = mIm;
    repeat (5) @(posedge clk);
    #1;
    expValid = 1'b1;
    expBusy  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison of the 4-point instance against the model's timeline.
  always @(negedge clk) begin
    if (compareOn) begin
      check("ready4", ready4, expValid);
      check("busy4", busy4, expBusy);
      if (expValid && ready4) begin
        check("re4", re4, expRe);
        check("im4", im4, expIm);
      end
    end
  end

  task automatic checkOutput32(input int k, input bit literalZero);
    logic [23:0] mRe, mIm;
    for (int i = 0; i < 32; i++) begin
      sr32[i] = srcR[i][23:0];
      si32[i] = srcI[i][23:0];
    end
    model(32, k, 1'b0, mRe, mIm);
    idx32   = 5'(k);
    inv32   = 1'b0;
    start32 = 1'b1;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    check("ready32_early", ready32, 1'b0);
    check("busy32_round", busy32, 1'b1);
    @(posedge clk);
    #1;
    check("ready32", ready32, 1'b1);
    check("re32", re32, mRe);
    check("im32", im32, mIm);
    if (literalZero) begin
      check("sq_zero_re", re32, 24'h000000);
      check("sq_zero_im", im32, 24'h000000);
    end
  endtask

  initial begin
    logic signed [23:0] t;
    reset     = 1'b1;
    start4    = 1'b0;
    inv4      = 1'b0;
    idx4      = '0;
    sr4       = '0;
    si4       = '0;
    start32   = 1'b0;
    inv32     = 1'b0;
    idx32     = '0;
    sr32      = '0;
    si32      = '0;
    compareOn = 1'b0;
    expValid  = 1'b0;
    expBusy   = 1'b0;
    expRe     = '0;
    expIm     = '0;
    for (int i = 0; i < 32; i++) begin
      srcR[i] = 0;
      srcI[i] = 0;
    end
    #12;
    check("rst_ready", ready4, 1'b0);
    check("rst_busy", busy4, 1'b0);
    check("rst_re", re4, 24'h0);
    check("rst_im", im4, 24'h0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    compareOn = 1'b1;

    // Four-bin forward transform of {2,1,2,0} in Q.8.
    srcR[0] = 64'sh200; srcR[1] = 64'sh100; srcR[2] = 64'sh200; srcR[3] = 0;
    for (int k = 0; k < 4; k++) begin
      runStart4(k, 1'b0);
      check("lit_fwd_re", re4, litRe[k]);
      check("lit_fwd_im", im4, litIm[k]);
    end

    // A start while busy must not disturb the running k=2 computation.
    applyStimulus4();
    idx4   = 2'd2;
    inv4   = 1'b0;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4   = 1'b0;
    expValid = 1'b0;
    expBusy  = 1'b1;
    expRe    = 24'h000300;
    expIm    = 24'h000000;
    repeat (2) @(posedge clk);
    #1;
    idx4   = 2'd1;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expValid = 1'b1;
    expBusy  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("ignored_start_re", re4, 24'h000300);
    check("ignored_start_im", im4, 24'h000000);

    // Reset mid-accumulation aborts immediately, then a fresh k=1 run completes.
    idx4   = 2'd0;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4   = 1'b0;
    expValid = 1'b0;
    expBusy  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b1;
    expBusy = 1'b0;
    #1;
    check("abort_busy", busy4, 1'b0);
    check("abort_ready", ready4, 1'b0);
    check("abort_re", re4, 24'h0);
    check("abort_im", im4, 24'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    runStart4(1, 1'b0);
    check("restart_re", re4, 24'h000000);
    check("restart_im", im4, 24'hffff00);

    // Scaled inverse of an impulse spectrum.
    srcR[0] = 64'sh400; srcR[1] = 0; srcR[2] = 0; srcR[3] = 0;
    for (int k = 0; k < 4; k++) begin
      runStart4(k, 1'b1);
      check("lit_inv_re", re4, 24'h000100);
      check("lit_inv_im", im4, 24'h000000);
    end

    // Saturation at both rails.
    for (int i = 0; i < 4; i++) srcR[i] = 64'sh7fffff;
    runStart4(0, 1'b0);
    check("sat_pos_re", re4, 24'h7fffff);
    check("sat_pos_im", im4, 24'h000000);
    for (int i = 0; i < 4; i++) srcR[i] = -64'sh800000;
    runStart4(0, 1'b0);
    check("sat_neg_re", re4, 24'h800000);

    // Randomized vectors, bins and directions.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 4; i++) begin
        t = 24'($urandom);
        srcR[i] = t;
        t = 24'($urandom);
        srcI[i] = t;
      end
      runStart4(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // 32-point square wave: odd bins and DC cancel exactly.
    for (int i = 0; i < 32; i++) begin
      srcR[i] = (((i / 8) % 2) == 0) ? 64'sh100 : -64'sh100;
      srcI[i] = 0;
    end
    for (int k = 0; k < 32; k++) begin
      checkOutput32(k, (k == 0) || ((k % 2) == 1));
    end

    compareOn = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
